// File: rtl/axis_window_gen_pkg.sv
// Shared constants and helpers for the streaming window generator.
// Window element (r,c) packs oldest row/column first.
package axis_window_gen_pkg;

    localparam int KSIZE_3 = 3;
    localparam int KSIZE_5 = 5;

    typedef struct packed {
        logic user;
        logic last;
    } win_flags_t;

    function automatic int win_offset(
        input int r,
        input int c,
        input int k,
        input int dw
    );
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/axis_line_buffer.sv
// One image line of pixel storage: combinational read, clocked write,
// so a same-address access returns the old entry (read-before-write).
module axis_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/axis_window_gen.sv
// AXI-Stream KSIZE x KSIZE sliding window generator ("valid" convolution).
// Line buffers feed a register window; the window doubles as the output register.
module axis_window_gen
    import axis_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH            = 8,
    parameter int IMAGE_WIDTH           = 512,
    parameter int IMAGE_HEIGHT          = 512,
    parameter int IMAGE_WIDTH_LOG2_SIZE = 9,
    parameter int KSIZE                 = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic                                s_axis_tuser,
    input  logic                                s_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                                m_axis_tuser,
    output logic                                m_axis_tlast,
    output logic                                frame_done,
    output logic                                sync_err
);

    localparam int CW  = IMAGE_WIDTH_LOG2_SIZE;
    localparam int NLB = KSIZE - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] EDGE     = CW'(KSIZE - 1);

    if (KSIZE != KSIZE_3 && KSIZE != KSIZE_5) begin : g_bad_ksize
        $error("axis_window_gen: KSIZE must be 3 or 5");
    end

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb_rd  [NLB];
    logic [DATA_WIDTH-1:0] col_in [KSIZE];
    logic [DATA_WIDTH-1:0] win    [KSIZE][KSIZE];
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic                  emit;
    logic                  user_err;
    logic                  last_err;
    win_flags_t            flags;

    assign s_axis_tready = rst_n & enable
                         & (~m_axis_tvalid | m_axis_tready);
    assign accept   = s_axis_tvalid & s_axis_tready;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    assign emit     = (row >= EDGE) && (col >= EDGE);
    assign user_err = s_axis_tuser & ~last_col;
    assign last_err = s_axis_tlast & ~(last_col & last_row);

    assign flags.user = emit & last_col;
    assign flags.last = emit & last_col & last_row;

    // Buffer i holds the line i+1 rows above the incoming pixel.
    for (genvar i = 0; i < NLB; i++) begin : g_lb
        logic [DATA_WIDTH-1:0] wdata;
        if (i == 0) begin : g_head
            assign wdata = s_axis_tdata;
        end else begin : g_tail
            assign wdata = lb_rd[i-1];
        end
        axis_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMAGE_WIDTH),
            .ADDR_WIDTH (CW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wdata),
            .rdata (lb_rd[i])
        );
    end

    assign col_in[KSIZE-1] = s_axis_tdata;
    for (genvar r = 0; r < NLB; r++) begin : g_col
        assign col_in[r] = lb_rd[NLB-1-r];
    end

    // Window only shifts on accept, which never happens while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KSIZE-1] <= col_in[r];
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                m_axis_tdata[win_offset(r, c, KSIZE, DATA_WIDTH) +: DATA_WIDTH]
                    = win[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            row           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            frame_done <= m_axis_tvalid & m_axis_tready & m_axis_tlast;
            if (accept) begin
                m_axis_tvalid <= emit;
                m_axis_tuser  <= flags.user;
                m_axis_tlast  <= flags.last;
                if (user_err | last_err) begin
                    sync_err <= 1'b1;
                end
                if (s_axis_tlast) begin
                    col <= '0;
                    row <= '0;
                end else if (s_axis_tuser | last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_window_gen.sv
// Self-checking bench: 8x8 frames into K=3 and K=5 window generators
// against a frame-array reference model.
module tb_axis_window_gen;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        logic [199:0] data;
        bit           user;
        bit           last;
    } exp_t;

    typedef struct {
        int phase;
        bit en;
        bit mr;
        bit rdy;
    } rdy_vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_user;
    logic         s_last;
    logic         s_ready3;
    logic         m_valid3;
    logic         m_ready3;
    logic [71:0]  m_data3;
    logic         m_user3;
    logic         m_last3;
    logic         fd3;
    logic         se3;
    logic         s_valid5;
    logic         s_ready5;
    logic         m_valid5;
    logic         m_ready5;
    logic [199:0] m_data5;
    logic         m_user5;
    logic         m_last5;
    logic         fd5;
    logic         se5;

    // K=5 instance sees exactly the pixels the K=3 instance accepts.
    assign s_valid5 = s_valid & s_ready3;
    assign m_ready5 = 1'b1;

    always #5 clk = ~clk;

    axis_window_gen #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
        .IMAGE_WIDTH_LOG2_SIZE(3), .KSIZE(3)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready3),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user),
        .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid3), .m_axis_tready(m_ready3),
        .m_axis_tdata(m_data3), .m_axis_tuser(m_user3),
        .m_axis_tlast(m_last3),
        .frame_done(fd3), .sync_err(se3)
    );

    axis_window_gen #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
        .IMAGE_WIDTH_LOG2_SIZE(3), .KSIZE(5)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_axis_tvalid(s_valid5), .s_axis_tready(s_ready5),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user),
        .s_axis_tlast(s_last),
        .m_axis_tvalid(m_valid5), .m_axis_tready(m_ready5),
        .m_axis_tdata(m_data5), .m_axis_tuser(m_user5),
        .m_axis_tlast(m_last5),
        .frame_done(fd5), .sync_err(se5)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] img [H][W];
    int   mr = 0;
    int   mc = 0;
    bit   mse = 0;
    bit   dchk = 1;
    exp_t q3[$];
    exp_t q5[$];

    // Per-frame statistics
    int w3, u3, l3, f3n, w5, u5, l5, f5n;
    logic [199:0] last5_data;

    // Monitor pipeline state
    bit st3 = 0, st5 = 0, tl3 = 0, tl5 = 0;
    logic [71:0]  h_data3;
    logic [199:0] h_data5;
    bit h_user3, h_last3, h_user5, h_last5;

    int rmode = 0;

    task automatic check(input string nm, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [199:0] mk_win(input int r, input int c,
                                            input int k);
        logic [199:0] w = '0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                w[(i*k+j)*8 +: 8] = img[r-k+1+i][c-k+1+j];
            end
        end
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] d, input bit u,
                                input bit l);
        exp_t e;
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            e.data = mk_win(mr, mc, 3);
            e.user = (mc == W-1);
            e.last = (mc == W-1) && (mr == H-1);
            q3.push_back(e);
        end
        if (mr >= 4 && mc >= 4) begin
            e.data = mk_win(mr, mc, 5);
            e.user = (mc == W-1);
            e.last = (mc == W-1) && (mr == H-1);
            q5.push_back(e);
        end
        if (u && mc != W-1) mse = 1;
        if (l && !(mc == W-1 && mr == H-1)) mse = 1;
        if (l) begin
            mr = 0;
            mc = 0;
        end else if (u || mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rmode == 1) m_ready3 = 1'b1;
        else if (rmode == 2) m_ready3 = 1'($urandom % 2);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            st3 = 0; st5 = 0; tl3 = 0; tl5 = 0;
        end else begin
            if (st3) check("hold3", {m_valid3, m_user3, m_last3, m_data3},
                           {1'b1, h_user3, h_last3, h_data3});
            if (st5) check("hold5", {m_valid5, m_user5, m_last5, m_data5},
                           {1'b1, h_user5, h_last5, h_data5});
            if (fd3 || tl3) check("done3", fd3, tl3);
            if (fd5 || tl5) check("done5", fd5, tl5);
            if (fd3) f3n++;
            if (fd5) f5n++;
            tl3 = 0;
            tl5 = 0;
            if (m_valid3 && m_ready3) begin
                w3++;
                if (m_user3) u3++;
                if (m_last3) begin l3++; tl3 = 1; end
                if (q3.size() == 0) begin
                    n_chk++;
                    $display("FAIL win3_extra: actual=unexpected window required=none");
                end else begin
                    e = q3.pop_front();
                    check("user3", m_user3, e.user);
                    check("last3", m_last3, e.last);
                    if (dchk) check("data3", m_data3, e.data[71:0]);
                end
            end
            if (m_valid5 && m_ready5) begin
                w5++;
                if (m_user5) u5++;
                if (m_last5) begin
                    l5++;
                    tl5 = 1;
                    last5_data = m_data5;
                end
                if (q5.size() == 0) begin
                    n_chk++;
                    $display("FAIL win5_extra: actual=unexpected window required=none");
                end else begin
                    e = q5.pop_front();
                    check("user5", m_user5, e.user);
                    check("last5", m_last5, e.last);
                    if (dchk) check("data5", m_data5, e.data);
                end
            end
            st3 = m_valid3 && !m_ready3;
            h_data3 = m_data3; h_user3 = m_user3; h_last3 = m_last3;
            st5 = m_valid5 && !m_ready5;
            h_data5 = m_data5; h_user5 = m_user5; h_last5 = m_last5;
            if (s_valid && s_ready3) model_accept(s_data, s_user, s_last);
        end
    end

    task automatic clear_stats();
        w3 = 0; u3 = 0; l3 = 0; f3n = 0;
        w5 = 0; u5 = 0; l5 = 0; f5n = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q3.delete();
        q5.delete();
        mr = 0; mc = 0; mse = 0;
        clear_stats();
        @(negedge clk);
        check("rst_valid", m_valid3, 1'b0);
        check("rst_ready", s_ready3, 1'b0);
        check("rst_data", m_data3, 72'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic send_px(input logic [7:0] d, input bit u, input bit l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
        forever begin
            @(negedge clk);
            if (s_ready3) break;
            n++;
            if (n > 500) begin
                n_chk++;
                $display("FAIL px_timeout: actual=no accept required=accept");
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q3.size() != 0 || q5.size() != 0 || m_valid3 || m_valid5)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_chk++;
            $display("FAIL drain: actual=%0d pending required=0", q3.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame_check(input string nm, input int ew3, input int eu3,
                               input int ew5, input int eu5);
        check({nm, "_w3"}, w3, ew3);
        check({nm, "_u3"}, u3, eu3);
        check({nm, "_l3"}, l3, 1);
        check({nm, "_fd3"}, f3n, 1);
        check({nm, "_w5"}, w5, ew5);
        check({nm, "_u5"}, u5, eu5);
        check({nm, "_l5"}, l5, 1);
        check({nm, "_fd5"}, f5n, 1);
        check({nm, "_se3"}, se3, mse);
        check({nm, "_se5"}, se5, mse);
    endtask

    // Sends one 8x8 frame; reset_at aborts it, gap_at stalls on enable.
    task automatic send_frame(input int gap_at, input int reset_at,
                              input bit rnd);
        logic [7:0] d;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r*W + c == reset_at) begin
                    do_reset();
                    return;
                end
                d = rnd ? 8'($urandom) : 8'(r*W + c);
                if (r*W + c == gap_at) begin
                    enable = 1'b0;
                    s_valid = 1'b1; s_data = d;
                    repeat (20) begin
                        @(negedge clk);
                        check("gap_ready", s_ready3, 1'b0);
                    end
                    @(posedge clk); #1;
                    enable = 1'b1;
                end
                send_px(d, c == W-1, (r == H-1) && (c == W-1));
            end
        end
    endtask

    rdy_vec_t rvec [7];
    logic [7:0] el [9];

    initial begin
        rvec[0] = '{0, 0, 0, 0};
        rvec[1] = '{0, 0, 1, 0};
        rvec[2] = '{0, 1, 0, 1};
        rvec[3] = '{0, 1, 1, 1};
        rvec[4] = '{1, 1, 0, 0};
        rvec[5] = '{1, 0, 0, 0};
        rvec[6] = '{1, 1, 1, 1};
        el = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};

        rst_n = 1'b0; enable = 1'b1; m_ready3 = 1'b0;
        s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);
        check("rst_valid", m_valid3, 1'b0);
        check("rst_data", m_data3, 72'd0);
        check("rst_flags", {m_user3, m_last3, fd3, se3}, 4'b0);
        check("rst_ready", s_ready3, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Frame 1: hold first window, probe ready, then full throughput.
        for (int i = 0; i < 4; i++) begin
            enable = rvec[i].en; m_ready3 = rvec[i].mr;
            @(negedge clk);
            check("rdy_idle", s_ready3, rvec[i].rdy);
            @(posedge clk); #1;
        end
        enable = 1'b1; m_ready3 = 1'b0;
        for (int p = 0; p < 19; p++) begin
            send_px(8'(p), 1'b0, 1'b0);
        end
        for (int i = 4; i < 7; i++) begin
            enable = rvec[i].en; m_ready3 = rvec[i].mr;
            @(negedge clk);
            check("rdy_busy", s_ready3, rvec[i].rdy);
            if (i == 5) begin
                for (int k = 0; k < 9; k++) begin
                    check("first_win", m_data3[k*8 +: 8], el[k]);
                end
            end
            @(posedge clk); #1;
        end
        enable = 1'b1; m_ready3 = 1'b1; rmode = 1;
        for (int p = 19; p < 64; p++) begin
            send_px(8'(p), (p % W) == W-1, p == 63);
        end
        drain();
        frame_check("f1", 36, 6, 16, 4);
        check("k5_centre", last5_data[12*8 +: 8], 8'd45);

        // Frame 2: random backpressure.
        clear_stats(); rmode = 2;
        send_frame(-1, -1, 1'b0);
        drain();
        frame_check("f2", 36, 6, 16, 4);

        // Frame 3: enable dropped mid-frame.
        clear_stats(); rmode = 1;
        send_frame(27, -1, 1'b0);
        drain();
        frame_check("f3", 36, 6, 16, 4);

        // Frame 4: reset after 30 pixels, then a clean frame.
        send_frame(-1, 30, 1'b0);
        send_frame(-1, -1, 1'b0);
        drain();
        frame_check("f4", 36, 6, 16, 4);

        // Frame 5: random pixels, random backpressure.
        clear_stats(); rmode = 2;
        send_frame(-1, -1, 1'b1);
        drain();
        frame_check("f5", 36, 6, 16, 4);

        // Frame 6: early end-of-line at row 2 col 5.
        clear_stats(); rmode = 1; dchk = 0;
        check("se_before", se3, 1'b0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!(r == 2 && c > 5)) begin
                    send_px(8'($urandom), (c == W-1) || (r == 2 && c == 5),
                            (r == H-1) && (c == W-1));
                    if (r == 2 && c == 5) begin
                        @(negedge clk);
                        check("se_set3", se3, 1'b1);
                        check("se_set5", se5, 1'b1);
                        @(posedge clk); #1;
                    end
                end
            end
        end
        drain();
        frame_check("f6", 34, 5, 16, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_window_gen.md
AXIS_WINDOW_GEN -- requirements
Module: axis_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 512, pixels per line.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 512, lines per frame.
REQ-004 SHALL have parameter IMAGE_WIDTH_LOG2_SIZE, default 9, column/row counter width.
REQ-005 SHALL have parameter KSIZE, default 3, window edge, legal values 3 or 5.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  high = accept pixels; low = s_axis_tready held 0.
REQ-009 s_axis_tvalid / s_axis_tready  in / out  1 / 1  input pixel handshake.
REQ-010 s_axis_tdata  in  DATA_WIDTH  pixel.
REQ-011 s_axis_tuser  in  1  end of line; s_axis_tlast  in  1  last pixel of frame.
REQ-012 m_axis_tvalid / m_axis_tready  out / in  1 / 1  window handshake.
REQ-013 m_axis_tdata  out  KSIZE*KSIZE*DATA_WIDTH  window; element (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH], r=0 oldest row, c=0 oldest column.
REQ-014 m_axis_tuser  out  1  last window of output line; m_axis_tlast  out  1  last window of frame.
REQ-015 frame_done  out  1  one-cycle pulse when the tlast window is accepted.
REQ-016 sync_err  out  1  sticky: input tuser/tlast position mismatch.

Function
REQ-017 SHALL store KSIZE-1 previous lines in line buffers of IMAGE_WIDTH entries each, plus a KSIZE x KSIZE register window shifted one column per accepted pixel.
REQ-018 Column counter col 0..IMAGE_WIDTH-1, row counter row 0..IMAGE_HEIGHT-1; col wraps to 0 and row increments on the last pixel; both wrap to 0 after the last frame pixel.
REQ-019 An accepted pixel at (row,col) SHALL produce a window iff row >= KSIZE-1 and col >= KSIZE-1 ("valid" convolution); output frame = (IMAGE_WIDTH-KSIZE+1) x (IMAGE_HEIGHT-KSIZE+1) windows.
REQ-020 Window latency: m_axis_tvalid asserts the cycle after the accepting input handshake.
REQ-021 Single output register; s_axis_tready = enable AND (NOT m_axis_tvalid OR m_axis_tready); no window lost or duplicated under any backpressure pattern.
REQ-022 m_axis_tdata/tuser/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 m_axis_tuser=1 on window with col=IMAGE_WIDTH-1; m_axis_tlast=1 additionally when row=IMAGE_HEIGHT-1.
REQ-024 Input s_axis_tuser=1 with col != IMAGE_WIDTH-1, or s_axis_tlast=1 with (row,col) not the last pixel, SHALL set sync_err, and force col=0 (and row=0 on tlast) after that pixel.
REQ-025 Dropping enable mid-frame SHALL stall only; counters and buffers retained; already-valid output still drains.
REQ-026 No arithmetic on pixels; data pass unmodified into the window.

Reset
REQ-027 On rst_n=0 (asynchronous): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_done=0, sync_err=0, s_axis_tready=0, col=0, row=0; line-buffer contents need not be cleared.
REQ-028 Reset mid-frame discards the partial frame; first pixel after release is treated as (0,0).

Structure
REQ-029 Shared package SHALL hold the window index helper (r,c -> bit offset) and the legal KSIZE constants.
REQ-030 One sub-module axis_line_buffer (single-port-per-side RAM, IMAGE_WIDTH x DATA_WIDTH, read-before-write), instantiated KSIZE-1 times.

Verification
REQ-031 W=8,H=8,K=3, pixel=row*8+col, full throughput -> 36 windows; first window elements 0,1,2,8,9,10,16,17,18; tuser on every 6th; tlast and frame_done on 36th only.
REQ-032 Same frame, m_axis_tready random 50% -> identical 36-window sequence, outputs stable while stalled.
REQ-033 W=8,H=8,K=5 -> 16 windows; last window centre = 45; tlast on 16th.
REQ-034 s_axis_tuser asserted at col=5 of row 2 -> sync_err=1 and stays 1; next pixel treated as col 0 of row 3.
REQ-035 rst_n pulsed low after 30 input pixels, then full frame sent -> exactly 36 correct windows, no stale output.
REQ-036 enable low for 20 cycles mid-frame -> s_axis_tready=0 throughout; window sequence identical to REQ-031.
